// File: rtl/status_array_sweep.sv
// Flop-based valid/status array with one registered read port, one masked write
// port and a self-clearing init sweep. Define STATUS_BYPASS_EN for write-first reads.
module status_array_sweep #(
    parameter int unsigned TAG_WIDTH   = 1,
    parameter int unsigned NUM_BLOCKS  = 8,
    parameter int unsigned BLOCK_WIDTH = 1,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              i_halt,
    input  logic                              i_init,
    input  logic [TAG_WIDTH-1:0]              i_tag,
    input  logic [ADDR_WIDTH-1:0]             i_r_addr,
    input  logic                              i_r_valid,
    input  logic [ADDR_WIDTH-1:0]             i_w_addr,
    input  logic [NUM_BLOCKS*BLOCK_WIDTH-1:0] i_w_data,
    input  logic [NUM_BLOCKS-1:0]             i_w_wmask,
    input  logic                              i_w_valid,
    output logic [TAG_WIDTH-1:0]              o_tag,
    output logic [NUM_BLOCKS*BLOCK_WIDTH-1:0] o_data,
    output logic                              o_valid,
    output logic                              o_ready,
    output logic                              o_init_busy
);

    localparam int unsigned           ROW_WIDTH = NUM_BLOCKS * BLOCK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ctr_q, ctr_d;
    logic                   valid_q, valid_d;
    logic [ROW_WIDTH-1:0]   data_q, data_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;

    logic [ROW_WIDTH-1:0]   mem_q [DEPTH];
    logic [ROW_WIDTH-1:0]   mem_d [DEPTH];

    logic                   ready;
    logic                   rd_acc;
    logic                   wr_acc;
    logic [ROW_WIDTH-1:0]   bit_mask;
    logic [ROW_WIDTH-1:0]   wr_merge;
    logic [ROW_WIDTH-1:0]   rd_row;

    assign ready  = ~i_halt & (state_q == ST_IDLE) & ~i_init;
    assign rd_acc = i_r_valid & ready;
    assign wr_acc = i_w_valid & ready;

    always_comb begin
        bit_mask = '0;
        for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
            bit_mask[b*BLOCK_WIDTH +: BLOCK_WIDTH] = {BLOCK_WIDTH{i_w_wmask[b]}};
        end
    end

    assign wr_merge = (mem_q[i_w_addr] & ~bit_mask) | (i_w_data & bit_mask);

`ifdef STATUS_BYPASS_EN
    assign rd_row = (wr_acc && (i_w_addr == i_r_addr)) ? wr_merge : mem_q[i_r_addr];
`else
    assign rd_row = mem_q[i_r_addr];
`endif

    // Sweep clear and accepted writes can never coincide: writes need IDLE.
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
            if (!i_halt && (state_q == ST_INIT) && (ctr_q == ADDR_WIDTH'(r))) begin
                mem_d[r] = '0;
            end else if (wr_acc && (i_w_addr == ADDR_WIDTH'(r))) begin
                mem_d[r] = wr_merge;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (!i_halt) begin
            case (state_q)
                ST_INIT: begin
                    if (ctr_q == LAST_ROW) begin
                        state_d = ST_IDLE;
                        ctr_d   = '0;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_init) begin
                        state_d = ST_INIT;
                        ctr_d   = '0;
                    end
                end
                default: state_d = ST_INIT;
            endcase
            valid_d = rd_acc;
            data_d  = rd_acc ? rd_row : '0;
            tag_d   = rd_acc ? i_tag  : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_INIT;
            ctr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // Array rows carry no reset; the sweep clears them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_tag       = tag_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_ready     = ready;
    assign o_init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_status_array_sweep.sv
// Directed self-checking bench for status_array_sweep (TAG_WIDTH=4, 8x1-bit blocks, 16 rows).
module tb_status_array_sweep;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       i_halt;
    logic       i_init;
    logic [3:0] i_tag;
    logic [3:0] i_r_addr;
    logic       i_r_valid;
    logic [3:0] i_w_addr;
    logic [7:0] i_w_data;
    logic [7:0] i_w_wmask;
    logic       i_w_valid;
    logic [3:0] o_tag;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic       o_init_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    status_array_sweep #(
        .TAG_WIDTH  (4),
        .NUM_BLOCKS (8),
        .BLOCK_WIDTH(1),
        .DEPTH      (16)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_halt     (i_halt),
        .i_init     (i_init),
        .i_tag      (i_tag),
        .i_r_addr   (i_r_addr),
        .i_r_valid  (i_r_valid),
        .i_w_addr   (i_w_addr),
        .i_w_data   (i_w_data),
        .i_w_wmask  (i_w_wmask),
        .i_w_valid  (i_w_valid),
        .o_tag      (o_tag),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_init_busy(o_init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        i_halt    = 1'b0;
        i_init    = 1'b0;
        i_tag     = '0;
        i_r_addr  = '0;
        i_r_valid = 1'b0;
        i_w_addr  = '0;
        i_w_data  = '0;
        i_w_wmask = '0;
        i_w_valid = 1'b0;
    endtask

    // Counts consecutive busy samples; optionally halts for 5 edges starting at sample halt_at.
    task automatic count_busy(input int halt_at, output int n);
        n = 0;
        while (o_init_busy === 1'b1 && n < 100) begin
            n++;
            if (n == halt_at)     i_halt = 1'b1;
            if (n == halt_at + 5) i_halt = 1'b0;
            cyc();
        end
        i_halt = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [3:0] tag);
        i_r_addr  = addr;
        i_tag     = tag;
        i_r_valid = 1'b1;
        cyc();
        i_r_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input logic [7:0] mask);
        i_w_addr  = addr;
        i_w_data  = data;
        i_w_wmask = mask;
        i_w_valid = 1'b1;
        cyc();
        i_w_valid = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 0; r < 16; r++) begin
            do_read(4'(r), 4'(r));
            check({tag, "_valid"}, o_valid, 1);
            check({tag, "_data"}, o_data, 8'h00);
        end
    endtask

    initial begin
        idle_inputs();
        arst_n = 1'b0;
        cyc();
        cyc();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_tag", o_tag, 0);
        check("rst_busy", o_init_busy, 1);
        check("rst_ready", o_ready, 0);

        // 1: post-reset sweep lasts 16 cycles, array reads back clear
        arst_n = 1'b1;
        count_busy(-1, cnt);
        check("sweep1_len", cnt, 16);
        check("sweep1_ready", o_ready, 1);
        read_all_zero("t1");
        cyc();
        check("idle_valid", o_valid, 0);
        check("idle_data", o_data, 0);

        // 2: masked write then read with tag
        do_write(4'd3, 8'hFF, 8'h0F);
        do_read(4'd3, 4'hA);
        check("t2_data", o_data, 8'h0F);
        check("t2_tag", o_tag, 4'hA);
        check("t2_valid", o_valid, 1);

        // 3: same-cycle read/write collision, full and partial mask
        i_w_addr = 4'd5; i_w_data = 8'hAA; i_w_wmask = 8'hFF; i_w_valid = 1'b1;
        do_read(4'd5, 4'h5);
        i_w_valid = 1'b0;
`ifdef STATUS_BYPASS_EN
        check("t3_coll_full", o_data, 8'hAA);
`else
        check("t3_coll_full", o_data, 8'h00);
`endif
        do_read(4'd5, 4'h6);
        check("t3_after_full", o_data, 8'hAA);
        i_w_addr = 4'd3; i_w_data = 8'h30; i_w_wmask = 8'hF0; i_w_valid = 1'b1;
        do_read(4'd3, 4'h7);
        i_w_valid = 1'b0;
`ifdef STATUS_BYPASS_EN
        check("t3_coll_part", o_data, 8'h3F);
`else
        check("t3_coll_part", o_data, 8'h0F);
`endif
        do_read(4'd3, 4'h8);
        check("t3_after_part", o_data, 8'h3F);

        // 4a: halt holds outputs, blocks writes and ignores init
        do_write(4'd7, 8'h0F, 8'hFF);
        do_read(4'd7, 4'h9);
        check("t4_pre_data", o_data, 8'h0F);
        i_halt = 1'b1;
        i_w_addr = 4'd7; i_w_data = 8'hFF; i_w_wmask = 8'hFF; i_w_valid = 1'b1;
        i_init = 1'b1;
        #1;
        check("t4_halt_ready", o_ready, 0);
        for (int k = 0; k < 5; k++) cyc();
        check("t4_hold_data", o_data, 8'h0F);
        check("t4_hold_valid", o_valid, 1);
        check("t4_hold_tag", o_tag, 4'h9);
        check("t4_halt_busy", o_init_busy, 0);
        idle_inputs();
        cyc();
        check("t4_rel_valid", o_valid, 0);
        do_read(4'd7, 4'h1);
        check("t4_nowrite", o_data, 8'h0F);

        // 5: fill array, flush with colliding read/write, then clear sweep
        for (int r = 0; r < 16; r++) do_write(4'(r), 8'hFF, 8'hFF);
        do_read(4'd9, 4'h2);
        check("t5_filled", o_data, 8'hFF);
        i_init = 1'b1;
        i_r_addr = 4'd9; i_r_valid = 1'b1;
        i_w_addr = 4'd1; i_w_data = 8'h00; i_w_wmask = 8'hFF; i_w_valid = 1'b1;
        #1;
        check("t5_init_ready", o_ready, 0);
        cyc();
        idle_inputs();
        check("t5_drop_valid", o_valid, 0);
        count_busy(-1, cnt);
        check("t5_sweep_len", cnt, 16);
        read_all_zero("t5");

        // 4b: 5-cycle halt at ctr=7 stretches the sweep to 21 cycles
        i_init = 1'b1;
        cyc();
        i_init = 1'b0;
        count_busy(8, cnt);
        check("t4_halt_sweep", cnt, 21);

        // 6: reset at ctr=9 restarts the sweep
        i_init = 1'b1;
        cyc();
        i_init = 1'b0;
        cnt = 1;
        while (cnt < 10) begin
            cyc();
            cnt++;
        end
        check("t6_busy_mid", o_init_busy, 1);
        arst_n = 1'b0;
        cyc();
        arst_n = 1'b1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_busy", o_init_busy, 1);
        count_busy(-1, cnt);
        check("t6_sweep_len", cnt, 16);

        // 6b: reset during a read clears the outputs
        do_write(4'd3, 8'h5A, 8'hFF);
        i_r_addr = 4'd3; i_tag = 4'hC; i_r_valid = 1'b1;
        cyc();
        check("t6b_rd_data", o_data, 8'h5A);
        check("t6b_rd_tag", o_tag, 4'hC);
        arst_n = 1'b0;
        cyc();
        arst_n = 1'b1;
        i_r_valid = 1'b0;
        check("t6b_rst_valid", o_valid, 0);
        check("t6b_rst_data", o_data, 0);
        check("t6b_rst_tag", o_tag, 0);
        count_busy(-1, cnt);
        check("t6b_sweep_len", cnt, 16);
        do_read(4'd3, 4'h3);
        check("t6b_cleared", o_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
